// File: rtl/goertzel_pkg.sv
// goertzel_pkg: types and constants shared across the Goertzel datapath
package goertzel_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} feeder_state_t;
    localparam int GOERTZEL_BLOCK_LEN = 520;
    localparam int SAMPLE_W = 32;
endpackage

// File: rtl/goertzel_sample_feeder.sv
// goertzel_sample_feeder: fetches one sample per tick and hands it to the recursion stage; FEEDER_OVERRUN_CNT_EN adds overrun_cnt
module goertzel_sample_feeder
    import goertzel_pkg::*;
#(
    parameter int DEPTH = GOERTZEL_BLOCK_LEN,
    parameter int AW    = 10,
    parameter int DW    = SAMPLE_W
) (
    input  logic          clock,
    input  logic          aclr,
    input  logic          enable,
    input  logic          restart,
    input  logic          sample_tick,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_first,
    output logic          out_last,
    output logic          block_done,
    output logic          overrun
`ifdef FEEDER_OVERRUN_CNT_EN
    ,
    output logic [15:0]   overrun_cnt
`endif
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    feeder_state_t state;
    logic [AW-1:0] idx;
    logic          restart_pend;
    logic          fire;
    logic          drop;
    assign mem_addr = idx;
    assign fire     = out_valid & out_ready;
    assign drop     = sample_tick & (state != IDLE);
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state        <= IDLE;
            idx          <= '0;
            restart_pend <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_first    <= 1'b0;
            out_last     <= 1'b0;
            block_done   <= 1'b0;
        end else begin
            block_done <= fire & out_last;
            if (restart && state != IDLE)
                restart_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (restart)
                        idx <= '0;
                    if (sample_tick && enable)
                        state <= FETCH;
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    out_data  <= mem_data;
                    out_first <= (idx == '0);
                    out_last  <= (idx == LAST);
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: if (fire) begin
                    // a pending restart wins over the normal advance
                    idx          <= (restart_pend || restart) ? '0 : (idx == LAST) ? '0 : idx + 1'b1;
                    restart_pend <= 1'b0;
                    out_valid    <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef FEEDER_OVERRUN_CNT_EN
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr)
            overrun_cnt <= '0;
        else if (drop && overrun_cnt != 16'hFFFF)
            overrun_cnt <= overrun_cnt + 16'd1;
    end
    assign overrun = (overrun_cnt != 16'd0);
`else
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr)
            overrun <= 1'b0;
        else if (drop)
            overrun <= 1'b1;
    end
`endif
endmodule
